// File: rtl/avalon_mem_responder.sv
// Avalon-MM memory responder: byte-lane word RAM, programmable wait states, fixed read
// latency and bounded in-order read returns. Optional protocol checker: AVS_PROTOCOL_CHECK_EN.
module avalon_mem_responder #(
  parameter int ADDR_W       = 28,
  parameter int MEM_WORDS    = 4096,
  parameter int WAIT_STATES  = 2,
  parameter int READ_LATENCY = 1,
  parameter int MAX_PENDING  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [7:0]        d_byteenable,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [63:0]       d_writedata,
  output logic              d_waitrequest,
  output logic [63:0]       d_readdata,
  output logic              d_readdatavalid,
  output logic              err
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCEPT} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              wait_cnt_reg, wait_cnt_next;
  logic                    req, is_read, queue_full;
  logic                    accept, do_write, do_read;
  logic [IDX_W-1:0]        word_idx;
  logic [63:0]             rd_word, ret_data;
  logic [READ_LATENCY-1:0] pipe_valid_reg;
  int                      pend_count;
  logic                    unused_addr_bits;

  assign req      = d_read | d_write;
  // A simultaneous read and write is serviced as a write only.
  assign is_read  = d_read & ~d_write;
  assign word_idx = d_address[IDX_W+2:3];
  assign unused_addr_bits = ^{d_address[ADDR_W-1:IDX_W+3], d_address[2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    d_waitrequest = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          wait_cnt_next = WAIT_INIT;
          if (WAIT_STATES == 0 && !(is_read && queue_full)) state_next = ST_ACCEPT;
          else                                              state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_next = ST_IDLE;
        end else begin
          if (wait_cnt_reg != 4'd0) wait_cnt_next = wait_cnt_reg - 4'd1;
          // Counter reaching zero (or already parked there while stalled) releases the request.
          if (wait_cnt_reg <= 4'd1 && !(is_read && queue_full)) state_next = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        d_waitrequest = 1'b0;
        state_next    = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign accept   = (state_reg == ST_ACCEPT) & req & ~reset;
  assign do_write = accept & d_write;
  assign do_read  = accept & is_read;

  // One narrow RAM per byte lane keeps byte enables a plain per-lane write enable.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_WORDS];
      logic [7:0] lane_rd_reg;
      always_ff @(posedge clk) begin
        if (do_write && d_byteenable[gi]) lane_mem[word_idx] <= d_writedata[8*gi +: 8];
        lane_rd_reg <= lane_mem[word_idx];
      end
      assign rd_word[8*gi +: 8] = lane_rd_reg;
    end
  endgenerate

  // The RAM output register is the first latency stage; remaining stages are a delay line.
  generate
    if (READ_LATENCY == 1) begin : g_direct
      assign ret_data = rd_word;
    end else begin : g_delay
      logic [63:0] delay_reg [READ_LATENCY-1];
      always_ff @(posedge clk) begin
        delay_reg[0] <= rd_word;
        for (int k = 1; k < READ_LATENCY - 1; k++) delay_reg[k] <= delay_reg[k-1];
      end
      assign ret_data = delay_reg[READ_LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid_reg <= '0;
    end else begin
      pipe_valid_reg[0] <= do_read;
      for (int k = 1; k < READ_LATENCY; k++) pipe_valid_reg[k] <= pipe_valid_reg[k-1];
    end
  end

  // Every valid stage is an accepted read whose slot is not yet free, including the one returning now.
  always_comb begin
    pend_count = 0;
    for (int k = 0; k < READ_LATENCY; k++) pend_count = pend_count + int'(pipe_valid_reg[k]);
  end
  assign queue_full = (pend_count >= MAX_PENDING);

  assign d_readdatavalid = pipe_valid_reg[READ_LATENCY-1];
  assign d_readdata      = d_readdatavalid ? ret_data : 64'd0;

`ifdef AVS_PROTOCOL_CHECK_EN
  logic              err_reg, violation;
  logic [ADDR_W-1:0] cap_addr_reg;
  logic [7:0]        cap_be_reg;
  logic [63:0]       cap_wdata_reg;
  logic [1:0]        cap_kind_reg;

  always_ff @(posedge clk) begin
    if (state_reg == ST_IDLE && req) begin
      cap_addr_reg  <= d_address;
      cap_be_reg    <= d_byteenable;
      cap_wdata_reg <= d_writedata;
      cap_kind_reg  <= {d_read, d_write};
    end
  end

  always_comb begin
    violation = d_read & d_write;
    if (state_reg == ST_WAIT) begin
      if (!req || d_address != cap_addr_reg || d_byteenable != cap_be_reg ||
          d_writedata != cap_wdata_reg || {d_read, d_write} != cap_kind_reg)
        violation = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (violation) begin
      err_reg <= 1'b1;
`ifndef SYNTHESIS
      if (!err_reg) $error("avalon_mem_responder: protocol violation at address %h", d_address);
`endif
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Scoreboard bench for avalon_mem_responder: two instances (default timing, and a deep-latency
// shallow-queue variant) driven with directed and random traffic against an array memory model.
module tb_avalon_mem_responder;
  localparam int WS_A = 2, RL_A = 1, MP_A = 4, MW_A = 4096;
  localparam int WS_B = 0, RL_B = 4, MP_B = 2, MW_B = 64;
`ifdef AVS_PROTOCOL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct { logic [63:0] data; int due; } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  m_rst;
  logic [27:0] m_address [2];
  logic [7:0]  m_be [2];
  logic [63:0] m_wdata [2];
  logic [1:0]  m_read, m_write;
  logic [1:0]  m_wait, m_rvalid, m_err;
  logic [63:0] m_rdata [2];

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  logic [63:0] model_mem [2][4096];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_mem_responder #(.ADDR_W(28), .MEM_WORDS(MW_A), .WAIT_STATES(WS_A),
                         .READ_LATENCY(RL_A), .MAX_PENDING(MP_A)) u_dut_a (
    .clk(clk), .reset(m_rst[0]), .d_address(m_address[0]), .d_byteenable(m_be[0]),
    .d_read(m_read[0]), .d_write(m_write[0]), .d_writedata(m_wdata[0]),
    .d_waitrequest(m_wait[0]), .d_readdata(m_rdata[0]), .d_readdatavalid(m_rvalid[0]),
    .err(m_err[0]));

  avalon_mem_responder #(.ADDR_W(28), .MEM_WORDS(MW_B), .WAIT_STATES(WS_B),
                         .READ_LATENCY(RL_B), .MAX_PENDING(MP_B)) u_dut_b (
    .clk(clk), .reset(m_rst[1]), .d_address(m_address[1]), .d_byteenable(m_be[1]),
    .d_read(m_read[1]), .d_write(m_write[1]), .d_writedata(m_wdata[1]),
    .d_waitrequest(m_wait[1]), .d_readdata(m_rdata[1]), .d_readdatavalid(m_rvalid[1]),
    .err(m_err[1]));

  function automatic int ws_of(input int p); return (p == 0) ? WS_A : WS_B; endfunction
  function automatic int rl_of(input int p); return (p == 0) ? RL_A : RL_B; endfunction
  function automatic int words_of(input int p); return (p == 0) ? MW_A : MW_B; endfunction
  function automatic int word_of(input int p, input logic [27:0] addr);
    return int'(addr[27:3]) % words_of(p);
  endfunction

  function automatic int qsize(input int p);
    if (p == 0) return exp_q0.size();
    return exp_q1.size();
  endfunction
  function automatic exp_t qfront(input int p);
    if (p == 0) return exp_q0[0];
    return exp_q1[0];
  endfunction
  task automatic qpop(input int p);
    if (p == 0) void'(exp_q0.pop_front());
    else        void'(exp_q1.pop_front());
  endtask
  task automatic qpush(input int p, input exp_t e);
    if (p == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask
  task automatic qflush(input int p);
    if (p == 0) exp_q0.delete();
    else        exp_q1.delete();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Random byte address hitting word idx, with random aliasing upper bits and ignored low bits.
  function automatic logic [27:0] rand_addr(input int p, input int idx);
    logic [27:0] a;
    a = 28'($urandom);
    if (p == 0) a[14:3] = 12'(idx);
    else        a[8:3]  = 6'(idx);
    return a;
  endfunction

  // Called just after a negedge with the DUT idle; returns just after the negedge following accept.
  task automatic xfer(input int p, input bit rd, input bit wr, input logic [27:0] addr,
                      input logic [7:0] be, input logic [63:0] wdata, input bit chk_lat,
                      output int acc);
    int   start, n, idx;
    exp_t e;
    m_address[p] = addr; m_be[p] = be; m_wdata[p] = wdata;
    m_read[p] = rd; m_write[p] = wr;
    start = cyc;
    n = 0;
    while (m_wait[p] !== 1'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    check("accept_timeout", {63'd0, m_wait[p]}, 64'd0);
    // Request cycle in IDLE plus WAIT_STATES wait cycles, then the accept cycle.
    if (chk_lat) check("accept_latency", 64'(acc - start), 64'(ws_of(p) + 1));
    idx = word_of(p, addr);
    if (wr) begin
      for (int i = 0; i < 8; i++)
        if (be[i]) model_mem[p][idx][8*i +: 8] = wdata[8*i +: 8];
    end else if (rd) begin
      e.data = model_mem[p][idx];
      e.due  = acc + rl_of(p);
      qpush(p, e);
    end
    @(negedge clk);
    m_read[p] = 1'b0; m_write[p] = 1'b0;
  endtask

  task automatic drain(input int p);
    int n;
    n = 0;
    while (qsize(p) > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(qsize(p)), 64'd0);
    qflush(p);
  endtask

  task automatic monitor_port(input int p);
    exp_t e;
    if (m_rvalid[p] === 1'b1) begin
      if (qsize(p) == 0) begin
        check("unexpected_readdatavalid", {63'd0, m_rvalid[p]}, 64'd0);
      end else begin
        e = qfront(p);
        qpop(p);
        check("read_data", m_rdata[p], e.data);
        check("return_cycle", 64'(cyc), 64'(e.due));
      end
    end else begin
      check("idle_readdata", m_rdata[p], 64'd0);
      if (qsize(p) > 0) begin
        e = qfront(p);
        if (e.due < cyc) begin
          check("missing_return", {63'd0, m_rvalid[p]}, 64'd1);
          qpop(p);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      monitor_port(0);
      monitor_port(1);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int acc, acc_r [4];
    m_rst = 2'b11;
    m_read = '0; m_write = '0;
    for (int p = 0; p < 2; p++) begin
      m_address[p] = '0; m_be[p] = '0; m_wdata[p] = '0;
    end
    repeat (3) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      check("reset_waitrequest", {63'd0, m_wait[p]}, 64'd1);
      check("reset_readdatavalid", {63'd0, m_rvalid[p]}, 64'd0);
      check("reset_readdata", m_rdata[p], 64'd0);
      check("reset_err", {63'd0, m_err[p]}, 64'd0);
    end
    m_rst = 2'b00;
    mon_en = 1'b1;
    @(negedge clk);

    // Basic write then read-back on the default instance.
    xfer(0, 0, 1, 28'h0000100, 8'hFF, 64'hdaedbeefdeadbeef, 1, acc);
    xfer(0, 1, 0, 28'h0000100, 8'h00, 64'd0, 1, acc);
    // Partial byte-lane write merges with the preloaded word.
    xfer(0, 0, 1, 28'h0000200, 8'hFF, 64'h0102030405060708, 1, acc);
    xfer(0, 0, 1, 28'h0000200, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1, acc);
    xfer(0, 1, 0, 28'h0000200, 8'hFF, 64'd0, 1, acc);
    // Zero byteenable leaves the word untouched.
    xfer(0, 0, 1, 28'h0000200, 8'h00, 64'h5555555555555555, 1, acc);
    xfer(0, 1, 0, 28'h0000200, 8'hFF, 64'd0, 1, acc);
    // Read and write together: performed as a write, no return.
    xfer(0, 0, 1, 28'h0000008, 8'hFF, 64'h1111111111111111, 1, acc);
    xfer(0, 1, 1, 28'h0000008, 8'hF0, 64'h2222222222222222, 1, acc);
    check("err_read_write", {63'd0, m_err[0]}, {63'd0, EXP_ERR});
    xfer(0, 1, 0, 28'h0000008, 8'hFF, 64'd0, 1, acc);
    // Request dropped while waiting: no transfer, FSM returns to IDLE.
    m_address[0] = 28'h0000010; m_read[0] = 1'b1;
    @(negedge clk);
    m_read[0] = 1'b0;
    @(negedge clk);
    check("drop_waitrequest", {63'd0, m_wait[0]}, 64'd1);
    repeat (4) @(negedge clk);
    check("err_sticky", {63'd0, m_err[0]}, {63'd0, EXP_ERR});
    // Word index wraps: byte address MEM_WORDS*8 aliases word 0.
    xfer(0, 0, 1, 28'(MW_A * 8), 8'hFF, 64'h5, 1, acc);
    xfer(0, 1, 0, 28'h0000000, 8'hFF, 64'd0, 1, acc);

    // Random traffic on the default instance.
    for (int i = 0; i < 32; i++) xfer(0, 0, 1, rand_addr(0, i), 8'hFF, {$urandom, $urandom}, 1, acc);
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 1) == 1)
        xfer(0, 1, 0, rand_addr(0, $urandom_range(0, 31)), 8'($urandom), 64'd0, 1, acc);
      else
        xfer(0, 0, 1, rand_addr(0, $urandom_range(0, 31)), 8'($urandom), {$urandom, $urandom}, 1, acc);
    end
    drain(0);

    // Deep-latency instance: back-to-back reads against a two-entry queue.
    for (int i = 0; i < 4; i++) xfer(1, 0, 1, 28'(i * 8), 8'hFF, 64'(16 + i), 1, acc);
    for (int i = 0; i < 4; i++) xfer(1, 1, 0, 28'(i * 8), 8'hFF, 64'd0, (i < 2), acc_r[i]);
    check("second_accept_unstalled", 64'(acc_r[1] - acc_r[0]), 64'd2);
    check("third_accept_after_first_return", {63'd0, acc_r[2] > acc_r[0] + RL_B}, 64'd1);
    check("fourth_accept_after_second_return", {63'd0, acc_r[3] > acc_r[1] + RL_B}, 64'd1);
    drain(1);

    // Reset between accept and return drops the in-flight read.
    xfer(1, 1, 0, 28'h0000008, 8'hFF, 64'd0, 1, acc);
    m_rst[1] = 1'b1;
    qflush(1);
    @(negedge clk);
    m_rst[1] = 1'b0;
    check("midreset_waitrequest", {63'd0, m_wait[1]}, 64'd1);
    check("midreset_readdatavalid", {63'd0, m_rvalid[1]}, 64'd0);
    repeat (8) @(negedge clk);
    xfer(1, 1, 0, 28'h0000010, 8'hFF, 64'd0, 1, acc);
    drain(1);

    // Random traffic on the deep-latency instance; reads may stall, so only writes check timing.
    for (int i = 0; i < 16; i++) xfer(1, 0, 1, rand_addr(1, i), 8'hFF, {$urandom, $urandom}, 1, acc);
    for (int n = 0; n < 100; n++) begin
      if ($urandom_range(0, 2) != 0)
        xfer(1, 1, 0, rand_addr(1, $urandom_range(0, 15)), 8'($urandom), 64'd0, 0, acc);
      else
        xfer(1, 0, 1, rand_addr(1, $urandom_range(0, 15)), 8'($urandom), {$urandom, $urandom}, 1, acc);
    end
    drain(1);
    check("err_clean_port", {63'd0, m_err[1]}, 64'd0);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
